// File: rtl/lcd_hd44780_char_writer.sv
// HD44780 4-bit write-only character writer: runs the power-up init sequence,
// then writes one character at a time at a given 32-position cursor address.
module lcd_hd44780_char_writer #(
    parameter int SETUP_CYC    = 4,
    parameter int E_PULSE_CYC  = 25,
    parameter int NIB_GAP_CYC  = 50,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 100000,
    parameter int PWRUP_CYC    = 2500000,
    parameter int INIT1_CYC    = 205000,
    parameter int INIT2_CYC    = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_data,
    input  logic [4:0] cursor_pos,
    input  logic       write_enable,
    output logic       ready,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_db
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, E_PULSE_CYC), max_of(NIB_GAP_CYC, CMD_WAIT_CYC)),
                                    max_of(max_of(CLR_WAIT_CYC, PWRUP_CYC), max_of(INIT1_CYC, INIT2_CYC)));
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {S_PWRUP, S_INIT_NIB, S_INIT_BYTE, S_IDLE, S_WR_ADDR, S_WR_DATA} state_t;
    typedef enum logic [1:0] {P_SETUP, P_E_HIGH, P_GAP, P_WAIT} phase_t;

    state_t           state_reg;
    phase_t           phase_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       step_reg;
    logic             hi_nib_reg;
    logic [7:0]       byte_reg;
    logic [7:0]       char_reg;
    logic             ready_reg;
    logic             rs_reg;
    logic             e_reg;
    logic [3:0]       db_reg;
    logic [7:0]       init_next;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Post-transfer wait for the nibble/byte that was just sent (loaded as count-1).
    function automatic logic [CNT_W-1:0] wait_cyc(input state_t s, input logic [1:0] step);
        int w;
        w = CMD_WAIT_CYC;
        if (s == S_INIT_NIB && step == 2'd0)
            w = INIT1_CYC;
        else if (s == S_INIT_NIB && step == 2'd1)
            w = INIT2_CYC;
        else if (s == S_INIT_BYTE && step == 2'd2)
            w = CLR_WAIT_CYC;
        return CNT_W'(w - 1);
    endfunction

    always_comb begin
        init_next = init_byte((state_reg == S_INIT_NIB) ? 2'd0 : step_reg + 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_PWRUP;
            phase_reg  <= P_WAIT;
            cnt_reg    <= CNT_W'(PWRUP_CYC - 1);
            step_reg   <= 2'd0;
            hi_nib_reg <= 1'b0;
            byte_reg   <= 8'h00;
            char_reg   <= 8'h00;
            ready_reg  <= 1'b0;
            rs_reg     <= 1'b0;
            e_reg      <= 1'b0;
            db_reg     <= 4'h0;
        end else begin
            case (state_reg)
                S_PWRUP: begin
                    if (cnt_reg == '0) begin
                        state_reg  <= S_INIT_NIB;
                        step_reg   <= 2'd0;
                        hi_nib_reg <= 1'b0;
                        rs_reg     <= 1'b0;
                        db_reg     <= 4'h3;
                        phase_reg  <= P_SETUP;
                        cnt_reg    <= CNT_W'(SETUP_CYC - 1);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (write_enable) begin
                        ready_reg  <= 1'b0;
                        char_reg   <= char_data;
                        byte_reg   <= {1'b1, cursor_pos[4], 2'b00, cursor_pos[3:0]};
                        state_reg  <= S_WR_ADDR;
                        hi_nib_reg <= 1'b1;
                        rs_reg     <= 1'b0;
                        db_reg     <= {1'b1, cursor_pos[4], 2'b00};
                        phase_reg  <= P_SETUP;
                        cnt_reg    <= CNT_W'(SETUP_CYC - 1);
                    end
                end
                default: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        case (phase_reg)
                            P_SETUP: begin
                                e_reg     <= 1'b1;
                                phase_reg <= P_E_HIGH;
                                cnt_reg   <= CNT_W'(E_PULSE_CYC - 1);
                            end
                            P_E_HIGH: begin
                                e_reg     <= 1'b0;
                                phase_reg <= P_GAP;
                                cnt_reg   <= CNT_W'(NIB_GAP_CYC - 1);
                            end
                            P_GAP: begin
                                if (hi_nib_reg) begin
                                    hi_nib_reg <= 1'b0;
                                    db_reg     <= byte_reg[3:0];
                                    phase_reg  <= P_SETUP;
                                    cnt_reg    <= CNT_W'(SETUP_CYC - 1);
                                end else begin
                                    phase_reg <= P_WAIT;
                                    cnt_reg   <= wait_cyc(state_reg, step_reg);
                                end
                            end
                            default: begin
                                // Post-wait finished: start the next item of the sequence.
                                phase_reg <= P_SETUP;
                                cnt_reg   <= CNT_W'(SETUP_CYC - 1);
                                case (state_reg)
                                    S_INIT_NIB: begin
                                        if (step_reg == 2'd3) begin
                                            state_reg  <= S_INIT_BYTE;
                                            step_reg   <= 2'd0;
                                            byte_reg   <= init_next;
                                            db_reg     <= init_next[7:4];
                                            hi_nib_reg <= 1'b1;
                                        end else begin
                                            step_reg <= step_reg + 2'd1;
                                            db_reg   <= (step_reg == 2'd2) ? 4'h2 : 4'h3;
                                        end
                                    end
                                    S_INIT_BYTE: begin
                                        if (step_reg == 2'd3) begin
                                            state_reg <= S_IDLE;
                                            ready_reg <= 1'b1;
                                            rs_reg    <= 1'b0;
                                            db_reg    <= 4'h0;
                                        end else begin
                                            step_reg   <= step_reg + 2'd1;
                                            byte_reg   <= init_next;
                                            db_reg     <= init_next[7:4];
                                            hi_nib_reg <= 1'b1;
                                        end
                                    end
                                    S_WR_ADDR: begin
                                        state_reg  <= S_WR_DATA;
                                        rs_reg     <= 1'b1;
                                        byte_reg   <= char_reg;
                                        db_reg     <= char_reg[7:4];
                                        hi_nib_reg <= 1'b1;
                                    end
                                    default: begin
                                        state_reg <= S_IDLE;
                                        ready_reg <= 1'b1;
                                        rs_reg    <= 1'b0;
                                        db_reg    <= 4'h0;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign ready  = ready_reg;
    assign lcd_rs = rs_reg;
    assign lcd_e  = e_reg;
    assign lcd_db = db_reg;

endmodule
